// File: rtl/tx_slot_scheduler_pkg.sv
// Shared types and constants for the transmit slot scheduler.
// Channel count and index width are fixed here so the sub-module and the top agree.
package tx_sched_pkg;

  localparam int N_CH       = 3;
  localparam int CH_W       = 2;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } state_t;

endpackage

// File: rtl/tx_slot_scheduler_rr_next.sv
// Round-robin search: first enabled channel at or after the start index, wrapping.
// any_en is low when no channel is enabled; next_idx then echoes start.
module rr_next
  import tx_sched_pkg::*;
(
  input  logic [N_CH-1:0] ch_enable,
  input  logic [CH_W-1:0] start,
  output logic [CH_W-1:0] next_idx,
  output logic            any_en
);

  int              sum;
  logic [CH_W-1:0] pos;

  always_comb begin
    next_idx = start;
    any_en   = 1'b0;
    sum      = 0;
    pos      = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = int'(start) + i;
      if (sum >= N_CH) sum = sum - N_CH;
      pos = CH_W'(sum);
      if (!any_en && ch_enable[pos]) begin
        any_en   = 1'b1;
        next_idx = pos;
      end
    end
  end

endmodule

// File: rtl/tx_slot_scheduler.sv
// Time-slot round-robin arbiter sharing one AXI-Stream output among the channel streams.
// Each slot ends on beat count, idle timeout or owner disable, followed by a single bubble.
module tx_slot_scheduler
  import tx_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLOT_W  = 16,
  parameter int IDLE_TO = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_CH-1:0]        ch_enable,
  input  logic [SLOT_W-1:0]      slot_len,
  input  logic [N_CH-1:0]        adc_tvalid,
  input  logic [N_CH*DATA_W-1:0] adc_tdata,
  output logic [N_CH-1:0]        adc_tready,
  output logic                   out_tvalid,
  output logic [DATA_W-1:0]      out_tdata,
  output logic [CH_W-1:0]        out_chan,
  input  logic                   out_tready,
  output logic [N_CH-1:0]        grant,
  output logic                   slot_done
);

  localparam int              IDLE_W    = $clog2(IDLE_TO);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TO - 1);

  state_t              state, state_nxt;
  logic [CH_W-1:0]     owner, owner_nxt, rr_ptr, rr_ptr_nxt;
  logic [CH_W-1:0]     owner_inc, search_start, found_idx;
  logic                found_any;
  logic [SLOT_W-1:0]   beat_cnt, beat_cnt_nxt, beat_last;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic                ready_ok, accept;
  logic [DATA_W-1:0]   ch_data [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) ch_data[i] = adc_tdata[i*DATA_W +: DATA_W];
  end

  assign owner_inc    = (owner == CH_W'(N_CH - 1)) ? '0 : owner + CH_W'(1);
  assign search_start = (state == SWITCH) ? owner_inc : rr_ptr;
  assign beat_last    = (slot_len == '0) ? '0 : slot_len - SLOT_W'(1);
  // Output stage can take a beat when empty or draining this cycle.
  assign ready_ok     = !out_tvalid || out_tready;

  rr_next u_rr_next (
    .ch_enable (ch_enable),
    .start     (search_start),
    .next_idx  (found_idx),
    .any_en    (found_any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    idle_cnt_nxt = idle_cnt;
    adc_tready   = '0;
    grant        = '0;
    slot_done    = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (found_any) begin
          state_nxt = GRANT;
          owner_nxt = found_idx;
        end
      end
      GRANT: begin
        grant[owner] = 1'b1;
        if (!ch_enable[owner]) begin
          slot_done = 1'b1;
          state_nxt = SWITCH;
        end else begin
          adc_tready[owner] = ready_ok;
          accept            = adc_tvalid[owner] && ready_ok;
          if (accept) begin
            beat_cnt_nxt = beat_cnt + SLOT_W'(1);
            idle_cnt_nxt = '0;
            // >= so a shortened slot_len still ends the slot on the next beat
            if (beat_cnt >= beat_last) begin
              slot_done = 1'b1;
              state_nxt = SWITCH;
            end
          end else if (!adc_tvalid[owner]) begin
            if (idle_cnt == IDLE_LAST) begin
              slot_done = 1'b1;
              state_nxt = SWITCH;
            end else begin
              idle_cnt_nxt = idle_cnt + IDLE_W'(1);
            end
          end
        end
      end
      SWITCH: begin
        rr_ptr_nxt   = owner_inc;
        beat_cnt_nxt = '0;
        idle_cnt_nxt = '0;
        if (found_any) begin
          state_nxt = GRANT;
          owner_nxt = found_idx;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_chan   <= '0;
    end else if (accept) begin
      out_tvalid <= 1'b1;
      out_tdata  <= ch_data[owner];
      out_chan   <= owner;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Randomised bench for tx_slot_scheduler: a slot-level reference model predicts per-cycle
// grants and accepted beats; a separate monitor checks delivered output beats in order.
module tb_tx_slot_scheduler;
  import tx_sched_pkg::*;

  localparam int DW  = 128;
  localparam int SW  = 16;
  localparam int ITO = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [2:0]      ch_enable;
  logic [SW-1:0]   slot_len;
  logic [2:0]      adc_tvalid;
  logic [3*DW-1:0] adc_tdata;
  logic [2:0]      adc_tready;
  logic            out_tvalid;
  logic [DW-1:0]   out_tdata;
  logic [1:0]      out_chan;
  logic            out_tready;
  logic [2:0]      grant;
  logic            slot_done;

  always #5 clock = ~clock;

  tx_slot_scheduler #(.DATA_W(DW), .SLOT_W(SW), .IDLE_TO(ITO)) dut (
    .clock      (clock),
    .reset      (reset),
    .ch_enable  (ch_enable),
    .slot_len   (slot_len),
    .adc_tvalid (adc_tvalid),
    .adc_tdata  (adc_tdata),
    .adc_tready (adc_tready),
    .out_tvalid (out_tvalid),
    .out_tdata  (out_tdata),
    .out_chan   (out_chan),
    .out_tready (out_tready),
    .grant      (grant),
    .slot_done  (slot_done)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    chan;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_b;
  logic [DW-1:0] ch_d [3];
  int            checks = 0;
  int            errors = 0;

  // Reference model: phase 0 idle, 1 channel owns the output, 2 bubble between slots.
  int m_phase, m_owner, m_rr, m_beats, m_idle;
  bit m_ov;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_en(input logic [2:0] en, input int from);
    for (int i = 0; i < 3; i++)
      if (en[(from + i) % 3]) return (from + i) % 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_idle = 0; m_ov = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic [2:0] en, input int sl, input logic [2:0] v, input bit tr);
    logic [2:0] e_rdy, e_grant;
    bit         e_done, acc, rdy;
    int         nxt;
    e_rdy = '0; e_grant = '0; e_done = 0; acc = 0; rdy = 0;
    nxt = m_phase;
    @(negedge clock);
    for (int i = 0; i < 3; i++) ch_d[i] = {$urandom, $urandom, $urandom, $urandom};
    ch_enable  = en;
    slot_len   = SW'(sl);
    adc_tvalid = v;
    out_tready = tr;
    adc_tdata  = {ch_d[2], ch_d[1], ch_d[0]};
    #1;
    case (m_phase)
      0: if (en != 0) begin nxt = 1; m_owner = first_en(en, m_rr); end
      1: begin
        e_grant[m_owner] = 1'b1;
        if (!en[m_owner]) begin
          e_done = 1; nxt = 2;
        end else begin
          rdy = !m_ov || tr;
          e_rdy[m_owner] = rdy;
          acc = v[m_owner] && rdy;
          if (acc) begin
            m_beats++; m_idle = 0;
            if (m_beats >= ((sl == 0) ? 1 : sl)) begin e_done = 1; nxt = 2; end
          end else if (!v[m_owner]) begin
            m_idle++;
            if (m_idle >= ITO) begin e_done = 1; nxt = 2; end
          end
        end
      end
      default: begin
        m_rr = (m_owner + 1) % 3; m_beats = 0; m_idle = 0;
        if (en != 0) begin nxt = 1; m_owner = first_en(en, m_rr); end
        else nxt = 0;
      end
    endcase
    chk("grant", grant, e_grant);
    chk("adc_tready", adc_tready, e_rdy);
    chk("slot_done", slot_done, e_done);
    chk("out_tvalid", out_tvalid, m_ov);
    if (acc) begin
      exp_q.push_back({ch_d[m_owner], 2'(m_owner)});
      m_ov = 1;
    end else if (tr) begin
      m_ov = 0;
    end
    m_phase = nxt;
  endtask

  task automatic check_reset_outputs();
    chk("rst_grant", grant, 0);
    chk("rst_adc_tready", adc_tready, 0);
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tdata", out_tdata, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_slot_done", slot_done, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #3 reset = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Monitor: every delivered output beat must match the oldest accepted beat.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset === 1'b0 && out_tvalid === 1'b1 && out_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_beat: got unexpected beat chan %0d, expected none", out_chan);
        end else begin
          mon_b = exp_q.pop_front();
          chk("out_tdata", out_tdata, mon_b.data);
          chk("out_chan", out_chan, mon_b.chan);
        end
      end
    end
  end

  initial begin
    logic [2:0] en, v;
    int         sl;
    reset = 1'b1; ch_enable = '0; slot_len = '0; adc_tvalid = '0; adc_tdata = '0; out_tready = 1'b0;
    model_reset();
    #12 check_reset_outputs();
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 30; i++) step(3'b111, 4, 3'b111, 1);
    for (int i = 0; i < 20; i++) step(3'b010, 0, 3'b111, 1);
    for (int i = 0; i < 60; i++) step(3'b111, 8, 3'b110, 1);
    for (int i = 0; i < 3; i++)  step(3'b111, 8, 3'b111, 1);
    for (int i = 0; i < 5; i++)  step(3'b111, 8, 3'b111, 0);
    for (int i = 0; i < 10; i++) step(3'b111, 8, 3'b111, 1);

    for (int i = 0; i < 10 && m_phase != 1; i++) step(3'b111, 8, 3'b111, 1);
    step(3'b111, 8, 3'b111, 0);
    en = 3'b111 & ~(3'b001 << m_owner);
    step(en, 8, 3'b111, 0);
    for (int i = 0; i < 12; i++) step(en, 8, 3'b111, 1);

    for (int i = 0; i < 6; i++) step(3'b111, 5, 3'b111, 1);
    do_reset();
    for (int i = 0; i < 12; i++) step(3'b111, 3, 3'b111, 1);

    en = 3'b111; sl = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        en = 3'($urandom_range(0, 7));
        sl = $urandom_range(0, 6);
      end
      for (int c = 0; c < 3; c++) v[c] = ($urandom_range(0, 4) != 0);
      if (i % 1000 == 999) do_reset();
      step(en, sl, v, ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 20; i++) step(3'b000, 1, 3'b000, 1);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
